led_key_accum: RTL and testbench

// Parametrised key-driven LED accumulator; next generation of the board LED counter.

---
 rtl/led_key_accum.sv | 125 ++++++++++++
 tb/tb_led_key_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_key_accum.sv
// Key-driven LED accumulator: synchronised, debounced keys latch sticky presses
// that are folded into an LED_W-bit accumulator on each prescaler tick.

module led_key_lane #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          s1, s2, deb, deb_q;
  logic [CW-1:0] cnt;

  // cnt holds consecutive cycles that s2 has disagreed with deb
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= key;
      s2    <= s1;
      deb_q <= deb;
      if (s2 != deb) begin
        if (cnt == CW'(DEB_CYC - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = deb & ~deb_q;
endmodule

module led_key_accum #(
  parameter int N_KEYS    = 4,
  parameter int LED_W     = 4,
  parameter int TICK_DIV  = 1600000,
  parameter int DEB_CYC   = 16,
  parameter int LED_ACT_L = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys,
  input  logic [1:0]        mode,
  input  logic              clr,
  output logic [LED_W-1:0]  led,
  output logic              tick,
  output logic              ovf
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_ROT  = 2'b10;
  localparam logic [LED_W-1:0] LED_OFF = (LED_ACT_L != 0) ? {LED_W{1'b1}} : {LED_W{1'b0}};

  logic [PW-1:0]     pcnt;
  logic [N_KEYS-1:0] rise, pending;
  logic [LED_W-1:0]  acc, rot;
  logic [LED_W:0]    sum;

  led_key_lane #(.DEB_CYC(DEB_CYC)) u_lane [N_KEYS-1:0] (
    .clk   (clk),
    .reset (reset),
    .key   (keys),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == PW'(TICK_DIV - 1));
  assign sum  = {1'b0, acc} + {1'b0, LED_W'(pending)};
  // Shift-or form also covers LED_W == 1, where rotation is the identity
  assign rot  = (acc << 1) | (acc >> (LED_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      led     <= LED_OFF;
    end else if (clr) begin
      pending <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      led     <= LED_OFF;
    end else if (tick) begin
      // Edges arriving on the tick cycle survive into the next window
      pending <= rise;
      led     <= (LED_ACT_L != 0) ? ~acc : acc;
      case (mode)
        M_WRAP: begin
          acc <= sum[LED_W-1:0];
          if (sum[LED_W]) ovf <= 1'b1;
        end
        M_SAT: begin
          if (sum[LED_W]) begin
            acc <= '1;
            ovf <= 1'b1;
          end else begin
            acc <= sum[LED_W-1:0];
          end
        end
        M_ROT:   acc <= rot;
        default: acc <= acc;
      endcase
    end else begin
      pending <= pending | rise;
    end
  end
endmodule

// File: tb/tb_led_key_accum.sv
// Directed bench for led_key_accum with a rule-level reference model checked every cycle.

module tb_led_key_accum;
  localparam int N_KEYS = 4, LED_W = 4, TICK_DIV = 10, DEB_CYC = 3;
  localparam int HL = 2 + DEB_CYC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys = '0;
  logic [1:0] mode = 2'b00;
  logic       clr = 1'b0;
  logic [3:0] led;
  logic       tick, ovf;

  int tests = 0;
  int fails = 0;

  led_key_accum #(
    .N_KEYS(N_KEYS), .LED_W(LED_W), .TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC), .LED_ACT_L(1)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .mode(mode), .clr(clr),
    .led(led), .tick(tick), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window-of-samples debounce, integer accumulator arithmetic
  logic [3:0] samp [0:HL-1];
  logic [3:0] m_deb = '0, m_rose = '0, m_pend = '0;
  int m_cnt = 0, m_acc = 0, m_led = 15, m_ovf = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < HL; j++) samp[j] = '0;
      m_deb = '0; m_rose = '0; m_pend = '0;
      m_cnt = 0; m_acc = 0; m_led = 15; m_ovf = 0;
    end else begin
      automatic bit tk = (m_cnt == TICK_DIV - 1);
      automatic logic [3:0] rs = m_rose;
      automatic int total;
      for (int j = HL - 1; j > 0; j--) samp[j] = samp[j-1];
      samp[0] = keys;
      for (int i = 0; i < N_KEYS; i++) begin
        automatic logic v = samp[2][i];
        automatic bit same = 1'b1;
        for (int j = 2; j < HL; j++) if (samp[j][i] != v) same = 1'b0;
        m_rose[i] = 1'b0;
        if (same && v != m_deb[i]) begin
          m_deb[i]  = v;
          m_rose[i] = v;
        end
      end
      if (clr) begin
        m_acc = 0; m_pend = '0; m_ovf = 0; m_led = 15;
      end else if (tk) begin
        m_led = 15 - m_acc;
        total = m_acc + int'(m_pend);
        case (mode)
          2'b00: begin if (total > 15) m_ovf = 1; m_acc = total % 16; end
          2'b01: begin if (total > 15) begin m_ovf = 1; m_acc = 15; end else m_acc = total; end
          2'b10: m_acc = (m_acc * 2) % 16 + m_acc / 8;
          default: ;
        endcase
        m_pend = rs;
      end else begin
        m_pend = m_pend | rs;
      end
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  end

  always @(posedge clk) begin
    #3;
    if (reset) begin
      check("led", int'(led), m_led);
      check("ovf", int'(ovf), m_ovf);
      check("tick", int'(tick), int'(m_cnt == TICK_DIV - 1));
    end
  end

  task automatic wait_tick_seen();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3 * TICK_DIV);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick_seen();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    keys = k;
    repeat (hold) @(negedge clk);
    keys = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int nt;
    // 1: reset and idle
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 15);
    check("rst_ovf", int'(ovf), 0);
    check("rst_tick", int'(tick), 0);
    reset = 1'b1;
    nt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("tick_count", nt, 5);
    check("idle_led", int'(led), 15);

    // 2: single press, then a long hold counted once
    press(4'b0010, 8);
    wait_ticks(1);
    check("k1_acc", m_acc, 2);
    wait_ticks(1);
    check("k1_led", int'(led), 4'b1101);
    press(4'b0010, 40);
    wait_ticks(2);
    check("hold_acc", m_acc, 4);
    check("hold_led", int'(led), 4'b1011);

    // 3: simultaneous keys and wrap
    clr_pulse();
    check("clr_led", int'(led), 15);
    press(4'b1001, 8);
    wait_ticks(1);
    check("k03_acc", m_acc, 9);
    check("k03_ovf", int'(ovf), 0);
    press(4'b1001, 8);
    wait_ticks(1);
    check("wrap_acc", m_acc, 2);
    check("wrap_ovf", int'(ovf), 1);
    wait_ticks(1);
    check("wrap_led", int'(led), 4'b1101);

    // 4: saturate
    clr_pulse();
    check("clr_ovf", int'(ovf), 0);
    press(4'b1001, 8);
    wait_ticks(1);
    press(4'b0101, 8);
    wait_ticks(1);
    check("pre_sat_acc", m_acc, 14);
    mode = 2'b01;
    press(4'b0100, 8);
    wait_ticks(1);
    check("sat_acc", m_acc, 15);
    check("sat_ovf", int'(ovf), 1);
    press(4'b0001, 8);
    wait_ticks(1);
    check("sat_hold", m_acc, 15);
    wait_ticks(1);
    check("sat_led", int'(led), 4'b0000);

    // 5: glitch rejected; press landing on the tick edge deferred one tick
    mode = 2'b00;
    clr_pulse();
    keys = 4'b0001;
    repeat (2) @(negedge clk);
    keys = '0;
    repeat (6) @(negedge clk);
    wait_ticks(2);
    check("glitch_acc", m_acc, 0);
    check("glitch_led", int'(led), 15);
    wait_tick_seen();
    repeat (5) @(negedge clk);
    keys = 4'b0001;
    repeat (8) @(negedge clk);
    keys = '0;
    check("edge_on_tick_acc", m_acc, 0);
    wait_ticks(1);
    check("edge_next_acc", m_acc, 1);
    wait_ticks(1);
    check("edge_led", int'(led), 4'b1110);

    // 6: rotate, reset mid-debounce, clr on a tick
    clr_pulse();
    press(4'b0011, 8);
    wait_ticks(1);
    check("rot_seed", m_acc, 3);
    mode = 2'b10;
    wait_ticks(1);
    check("rot1_acc", m_acc, 4'b0110);
    check("rot1_led", int'(led), 4'b1100);
    wait_ticks(1);
    check("rot2_acc", m_acc, 4'b1100);
    check("rot2_led", int'(led), 4'b1001);
    wait_ticks(1);
    check("rot3_acc", m_acc, 4'b1001);
    check("rot3_led", int'(led), 4'b0011);

    keys = 4'b0001;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_led", int'(led), 15);
    check("arst_ovf", int'(ovf), 0);
    check("arst_tick", int'(tick), 0);
    keys = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mode = 2'b00;
    wait_ticks(2);
    check("lost_press_led", int'(led), 15);
    check("lost_press_acc", m_acc, 0);

    press(4'b0100, 8);
    wait_ticks(1);
    check("pre_clr_acc", m_acc, 4);
    wait_tick_seen();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_tick_led", int'(led), 15);
    check("clr_tick_acc", m_acc, 0);
    wait_ticks(1);
    check("post_clr_led", int'(led), 15);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
